// File: rtl/lsu_dmem_responder.sv
// Data-memory responder for the LSU execute-stage request interface.
// Byte/half/word loads and stores on a little-endian, word-organised array.
// Loads return after READ_LATENCY cycles. Stores complete one cycle after sampling.
// Misaligned, out-of-range and reserved-size requests are rejected.
module lsu_dmem_responder #(
    parameter int unsigned DEPTH_WORDS  = 1024,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] rd_addr_i,
    input  logic        rd_en_i,
    input  logic [1:0]  rd_size_i,
    input  logic [31:0] wr_addr_i,
    input  logic [31:0] wr_data_i,
    input  logic        wr_en_i,
    input  logic [1:0]  wr_size_i,
    output logic [31:0] rd_data_o,
    output logic        rd_valid_o,
    output logic        rd_err_o,
    output logic        wr_done_o,
    output logic        wr_err_o
);

    localparam int unsigned IdxW      = $clog2(DEPTH_WORDS);
    localparam logic [32:0] ByteLimit = 33'(DEPTH_WORDS) << 2;

    // Error priority: reserved size, then misalignment, then range.
    function automatic logic req_err(logic [31:0] addr, logic [1:0] size);
        if (size == 2'b11) return 1'b1;
        if (size == 2'b01 && addr[0]) return 1'b1;
        if (size == 2'b10 && addr[1:0] != 2'b00) return 1'b1;
        return {1'b0, addr} >= ByteLimit;
    endfunction

    // Lane mask for an access starting at lane 0.
    function automatic logic [3:0] size_mask(logic [1:0] size);
        case (size)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    logic [31:0] mem [DEPTH_WORDS];

    logic            rd_err_c;
    logic [IdxW-1:0] rd_idx;
    logic [31:0]     rd_shifted;
    logic [31:0]     rd_keep;
    logic [31:0]     rd_word_c;

    logic            wr_err_c;
    logic [IdxW-1:0] wr_idx;
    logic [3:0]      wr_be;
    logic [31:0]     wr_lane_data;

    // Request decode: error flags, word index, lane alignment of load and store data.
    always_comb begin
        rd_err_c     = req_err(rd_addr_i, rd_size_i);
        rd_idx       = rd_addr_i[IdxW+1:2];
        rd_shifted   = mem[rd_idx] >> {rd_addr_i[1:0], 3'b000};
        rd_keep      = {{8{size_mask(rd_size_i)[3]}}, {8{size_mask(rd_size_i)[2]}},
                        {8{size_mask(rd_size_i)[1]}}, {8{size_mask(rd_size_i)[0]}}};
        rd_word_c    = (rd_en_i && !rd_err_c) ? (rd_shifted & rd_keep) : 32'h0;

        wr_err_c     = req_err(wr_addr_i, wr_size_i);
        wr_idx       = wr_addr_i[IdxW+1:2];
        wr_be        = (wr_en_i && !wr_err_c) ? (size_mask(wr_size_i) << wr_addr_i[1:0])
                                              : 4'b0000;
        wr_lane_data = wr_data_i << {wr_addr_i[1:0], 3'b000};
    end

    // Array write with byte enables; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) begin
                mem[wr_idx][8*b +: 8] <= wr_lane_data[8*b +: 8];
            end
        end
    end

    logic [READ_LATENCY-1:0] vld_q;
    logic [READ_LATENCY-1:0] err_q;
    logic [31:0]             dat_q [READ_LATENCY];

    // Read pipeline: stage 0 captures the old array word (read-before-write), then shifts.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
            err_q <= '0;
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                dat_q[i] <= 32'h0;
            end
        end else begin
            vld_q[0] <= rd_en_i;
            err_q[0] <= rd_en_i & rd_err_c;
            dat_q[0] <= rd_word_c;
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                vld_q[i] <= vld_q[i-1];
                err_q[i] <= err_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    logic wr_done_q;
    logic wr_err_q;

    // Store completion, one cycle after the store is sampled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_done_q <= 1'b0;
            wr_err_q  <= 1'b0;
        end else begin
            wr_done_q <= wr_en_i;
            wr_err_q  <= wr_en_i & wr_err_c;
        end
    end

    assign rd_valid_o = vld_q[READ_LATENCY-1];
    assign rd_err_o   = err_q[READ_LATENCY-1];
    assign rd_data_o  = dat_q[READ_LATENCY-1];
    assign wr_done_o  = wr_done_q;
    assign wr_err_o   = wr_err_q;

    // Flag unknown request strobes outside reset.
    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!$isunknown(rd_en_i)) else $error("rd_en_i is X");
            assert (!$isunknown(wr_en_i)) else $error("wr_en_i is X");
        end
    end

endmodule
